// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the branch target predictor.
//   WORD_SIZE : PC / target width, taken from the shared `WORD_SIZE define
//   ctr_t     : 2-bit saturating direction counter encoding
//   sat_inc / sat_dec : counter helpers that stick at the ends
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package branch_target_predictor_pkg;

    localparam int WORD_SIZE = `WORD_SIZE;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
// Ports:
//   ctr          in  current counter value
//   taken        in  resolved outcome (1 = taken)
//   force_strong in  unconditional transfer: a taken outcome jumps straight to CTR_ST
//   next_ctr     out counter value to store
module sat_counter2
    import branch_target_predictor_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    input  logic force_strong,
    output ctr_t next_ctr
);

    always_comb begin
        next_ctr = ctr;
        if (taken && force_strong) begin
            next_ctr = CTR_ST;
        end else if (taken) begin
            next_ctr = sat_inc(ctr);
        end else begin
            next_ctr = sat_dec(ctr);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// IF-stage next-PC predictor: direct-mapped BTB with a 2-bit counter per entry.
// Ports:
//   clk, reset        rising-edge clock; async active-high reset of all predictor state
//   PC                current fetch PC
//   predicted_nextPC  combinational next-PC prediction (PC+1 when no taken prediction)
//   predict_hit       lookup found a valid entry with matching tag
//   update_*          resolved control-transfer outcome from ID, trained on the clock edge
//   mispredict_count  saturating count of updates whose stored prediction was wrong
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int WORD_SIZE  = branch_target_predictor_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] PC,
    output logic [WORD_SIZE-1:0] predicted_nextPC,
    output logic                 predict_hit,
    input  logic                 update_en,
    input  logic [WORD_SIZE-1:0] update_PC,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_taken,
    input  logic                 update_uncond,
    output logic [15:0]          mispredict_count
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - INDEX_BITS;
    localparam logic [WORD_SIZE-1:0] ONE = 1;

    logic                 valid_mem  [ENTRIES];
    logic [TAG_W-1:0]     tag_mem    [ENTRIES];
    logic [WORD_SIZE-1:0] target_mem [ENTRIES];
    ctr_t                 ctr_mem    [ENTRIES];

    // Lookup path
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;

    assign idx = PC[INDEX_BITS-1:0];
    assign tag = PC[WORD_SIZE-1:INDEX_BITS];

    // Explicit reset gating keeps the outputs clean even before the arrays settle.
    assign predict_hit      = !reset && valid_mem[idx] && (tag_mem[idx] == tag);
    assign predicted_nextPC = (predict_hit && ctr_mem[idx][1]) ? target_mem[idx] : PC + ONE;

    // Update path
    logic [INDEX_BITS-1:0] uidx;
    logic [TAG_W-1:0]      utag;
    logic                  uhit;
    ctr_t                  ctr_base;
    ctr_t                  ctr_next;
    logic                  write_ctr;
    logic                  write_entry;
    logic [WORD_SIZE-1:0]  stored_pred;
    logic [WORD_SIZE-1:0]  actual_next;
    logic                  mispredict;

    assign uidx = update_PC[INDEX_BITS-1:0];
    assign utag = update_PC[WORD_SIZE-1:INDEX_BITS];
    assign uhit = valid_mem[uidx] && (tag_mem[uidx] == utag);

    // A fresh allocation behaves like incrementing a weakly-not-taken counter:
    // conditional -> CTR_WT, unconditional -> CTR_ST. This lets one counter
    // instance serve both the hit and the allocate cases.
    assign ctr_base = uhit ? ctr_mem[uidx] : CTR_WNT;

    sat_counter2 u_sat_counter2 (
        .ctr          (ctr_base),
        .taken        (update_taken),
        .force_strong (update_uncond),
        .next_ctr     (ctr_next)
    );

    // Miss + not-taken writes nothing; taken always (re)writes the entry.
    assign write_ctr   = update_en && (uhit || update_taken);
    assign write_entry = update_en && update_taken;

    assign stored_pred = (uhit && ctr_mem[uidx][1]) ? target_mem[uidx] : update_PC + ONE;
    assign actual_next = update_taken ? update_target : update_PC + ONE;
    assign mispredict  = update_en && (stored_pred != actual_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i] <= 1'b0;
                ctr_mem[i]   <= CTR_WNT;
            end
        end else begin
            if (write_ctr) begin
                ctr_mem[uidx] <= ctr_next;
            end
            if (write_entry) begin
                valid_mem[uidx] <= 1'b1;
            end
        end
    end

    // Tag and target carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (write_entry && !reset) begin
            tag_mem[uidx]    <= utag;
            target_mem[uidx] <= update_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict_count <= 16'h0000;
        end else if (mispredict && (mispredict_count != 16'hFFFF)) begin
            mispredict_count <= mispredict_count + 16'h0001;
        end
    end

endmodule
